// File: rtl/force_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : force_seq_pkg
// Purpose  : Shared types for the force/release sequencer and its FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package force_seq_pkg;

    localparam int c_cmd_width  = 8;
    localparam int c_cmd_hold_w = 8;

    typedef enum logic [1:0] {
        OP_FORCE       = 2'b00,
        OP_RELEASE     = 2'b01,
        OP_RELEASE_ALL = 2'b10,
        OP_RSVD        = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_HOLD    = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    typedef struct packed {
        op_e                     op;
        logic [c_cmd_width-1:0]  mask;
        logic [c_cmd_width-1:0]  value;
        logic [c_cmd_hold_w-1:0] hold;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/seq_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : seq_cmd_fifo
// Purpose  : Small synchronous command FIFO with async reset and flush.
// Revision : 1.0 - initial release
// ============================================================================
module seq_cmd_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == c_depth);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full && !flush;
    assign w_do_pop  = pop && !empty && !flush;
    assign pop_data  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/force_release_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : force_release_sequencer
// Purpose  : Serial force/release command sequencer driving a force-mux stage.
// Revision : 1.0 - initial release
// ============================================================================
module force_release_sequencer
    import force_seq_pkg::*;
#(
    parameter int WIDTH  = c_cmd_width,
    parameter int DEPTH  = 4,
    parameter int HOLD_W = c_cmd_hold_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [WIDTH-1:0]  cmd_mask,
    input  logic [WIDTH-1:0]  cmd_value,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    output logic [WIDTH-1:0]  force_en,
    output logic [WIDTH-1:0]  force_val,
    output logic              release_pulse,
    output logic [WIDTH-1:0]  release_mask,
    output logic              busy,
    output logic              err_op
);

    localparam logic [HOLD_W-1:0] c_hold_one = HOLD_W'(1);

    state_e            r_state;
    state_e            w_state_nxt;
    cmd_t              r_cmd;
    cmd_t              w_cmd_nxt;
    cmd_t              w_push_cmd;
    cmd_t              w_head_cmd;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_cnt_nxt;
    logic [WIDTH-1:0]  r_force_en;
    logic [WIDTH-1:0]  w_force_en_nxt;
    logic [WIDTH-1:0]  r_force_val;
    logic [WIDTH-1:0]  w_force_val_nxt;
    logic              r_release_pulse;
    logic [WIDTH-1:0]  r_release_mask;
    logic [WIDTH-1:0]  w_rel;
    logic [WIDTH-1:0]  w_rel_sel;
    logic              r_err_op;
    logic              w_err_op_nxt;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [$bits(cmd_t)-1:0] w_head_bits;

    assign w_push_cmd.op    = op_e'(cmd_op);
    assign w_push_cmd.mask  = cmd_mask;
    assign w_push_cmd.value = cmd_value;
    assign w_push_cmd.hold  = cmd_hold;
    assign w_head_cmd       = cmd_t'(w_head_bits);

    seq_cmd_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(cmd_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (cmd_valid && cmd_ready),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .pop_data  (w_head_bits),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign cmd_ready     = !w_full && !abort;
    assign busy          = (r_state != S_IDLE) || !w_empty;
    assign force_en      = r_force_en;
    assign force_val     = r_force_val;
    assign release_pulse = r_release_pulse;
    assign release_mask  = r_release_mask;
    assign err_op        = r_err_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_force_en_nxt  = r_force_en;
        w_force_val_nxt = r_force_val;
        w_err_op_nxt    = r_err_op;
        w_rel           = '0;
        w_rel_sel       = '0;
        w_pop           = 1'b0;

        if (abort) begin
            w_state_nxt    = S_IDLE;
            w_hold_cnt_nxt = '0;
            w_force_en_nxt = '0;
            w_rel          = r_force_en;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_cmd_nxt   = w_head_cmd;
                        w_state_nxt = S_APPLY;
                    end
                end
                S_APPLY: begin
                    w_state_nxt = S_IDLE;
                    case (r_cmd.op)
                        OP_FORCE: begin
                            w_force_en_nxt  = r_force_en | r_cmd.mask;
                            w_force_val_nxt = (r_force_val & ~r_cmd.mask) | (r_cmd.value & r_cmd.mask);
                            if (r_cmd.hold != '0) begin
                                w_hold_cnt_nxt = r_cmd.hold;
                                w_state_nxt    = S_HOLD;
                            end
                        end
                        OP_RELEASE, OP_RELEASE_ALL: begin
                            w_rel_sel      = (r_cmd.op == OP_RELEASE_ALL) ? '1 : r_cmd.mask;
                            w_rel          = r_force_en & w_rel_sel;
                            w_force_en_nxt = r_force_en & ~w_rel_sel;
                        end
                        default: w_err_op_nxt = 1'b1;
                    endcase
                end
                S_HOLD: begin
                    // Counter is checked before decrementing so hold=N yields N+1 forced cycles.
                    if (r_hold_cnt <= c_hold_one) w_state_nxt    = S_RELEASE;
                    else                          w_hold_cnt_nxt = r_hold_cnt - c_hold_one;
                end
                S_RELEASE: begin
                    w_rel          = r_force_en & r_cmd.mask;
                    w_force_en_nxt = r_force_en & ~r_cmd.mask;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd           <= '0;
            r_hold_cnt      <= '0;
            r_force_en      <= '0;
            r_force_val     <= '0;
            r_release_pulse <= 1'b0;
            r_release_mask  <= '0;
            r_err_op        <= 1'b0;
        end else begin
            r_cmd           <= w_cmd_nxt;
            r_hold_cnt      <= w_hold_cnt_nxt;
            r_force_en      <= w_force_en_nxt;
            r_force_val     <= w_force_val_nxt;
            r_release_pulse <= (w_rel != '0);
            r_release_mask  <= w_rel;
            r_err_op        <= w_err_op_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_force_release_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_force_release_sequencer
// Purpose  : Self-checking bench with a schedule-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_force_release_sequencer;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;
    localparam int HOLD_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [WIDTH-1:0]  cmd_mask;
    logic [WIDTH-1:0]  cmd_value;
    logic [HOLD_W-1:0] cmd_hold;
    logic              abort;
    logic [WIDTH-1:0]  force_en;
    logic [WIDTH-1:0]  force_val;
    logic              release_pulse;
    logic [WIDTH-1:0]  release_mask;
    logic              busy;
    logic              err_op;

    force_release_sequencer #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_mask      (cmd_mask),
        .cmd_value     (cmd_value),
        .cmd_hold      (cmd_hold),
        .abort         (abort),
        .force_en      (force_en),
        .force_val     (force_val),
        .release_pulse (release_pulse),
        .release_mask  (release_mask),
        .busy          (busy),
        .err_op        (err_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         op;
        logic [7:0] mask;
        logic [7:0] value;
        logic [7:0] hold;
    } mcmd_t;

    // Model: commands are scheduled by edge index rather than stepped through states.
    mcmd_t      mq[$];
    mcmd_t      cur;
    int         t;
    int         free_at;
    int         apply_at;
    int         release_at;
    logic [7:0] m_en;
    logic [7:0] m_val;
    logic [7:0] m_rmask;
    logic       m_pulse;
    logic       m_err;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at t=%0d: got 0x%0h expected 0x%0h", tag, t, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        t          = 0;
        free_at    = 0;
        apply_at   = -1;
        release_at = -1;
        m_en       = '0;
        m_val      = '0;
        m_rmask    = '0;
        m_pulse    = 1'b0;
        m_err      = 1'b0;
    endtask

    task automatic check_outputs();
        chk("force_en",      force_en,      m_en);
        chk("force_val",     force_val,     m_val);
        chk("release_pulse", release_pulse, m_pulse);
        chk("release_mask",  release_mask,  m_rmask);
        chk("busy",          busy,          (mq.size() > 0) || (free_at > t));
        chk("err_op",        err_op,        m_err);
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] mk,
                        input logic [7:0] vl, input logic [7:0] hd, input logic ab);
        logic       acc;
        logic [7:0] rel;
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op;
        cmd_mask  = mk;
        cmd_value = vl;
        cmd_hold  = hd;
        abort     = ab;
        #1;
        chk("cmd_ready", cmd_ready, (mq.size() < DEPTH) && !ab);
        acc = v && !ab && (mq.size() < DEPTH);
        rel = '0;
        if (ab) begin
            rel        = m_en;
            m_en       = '0;
            mq.delete();
            apply_at   = -1;
            release_at = -1;
            free_at    = t + 1;
        end else begin
            if (t == apply_at) begin
                case (cur.op)
                    0: begin
                        m_en  = m_en | cur.mask;
                        m_val = (m_val & ~cur.mask) | (cur.value & cur.mask);
                    end
                    1: rel = m_en & cur.mask;
                    2: rel = m_en;
                    default: m_err = 1'b1;
                endcase
                m_en = m_en & ~rel;
            end
            if (t == release_at) begin
                rel  = m_en & cur.mask;
                m_en = m_en & ~rel;
            end
            if (mq.size() > 0 && t >= free_at) begin
                cur      = mq.pop_front();
                apply_at = t + 1;
                if (cur.op == 0 && cur.hold != 0) begin
                    release_at = t + 2 + int'(cur.hold);
                    free_at    = t + 3 + int'(cur.hold);
                end else begin
                    free_at = t + 2;
                end
            end
            if (acc) mq.push_back('{int'(op), mk, vl, hd});
        end
        m_pulse = (rel != 0);
        m_rmask = rel;
        @(posedge clk);
        #1;
        t++;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] mk, input logic [7:0] vl,
                        input logic [7:0] hd);
        step(1'b1, op, mk, vl, hd, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        #1;
        model_reset();
        chk("rst_force_en",      force_en,      8'h00);
        chk("rst_force_val",     force_val,     8'h00);
        chk("rst_release_pulse", release_pulse, 1'b0);
        chk("rst_release_mask",  release_mask,  8'h00);
        chk("rst_busy",          busy,          1'b0);
        chk("rst_err_op",        err_op,        1'b0);
        chk("rst_cmd_ready",     cmd_ready,     1'b1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_mask  = '0;
        cmd_value = '0;
        cmd_hold  = '0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Sticky force, then a timed force with hold=3.
        send(2'b00, 8'h40, 8'h40, 8'd0);
        idle(5);
        send(2'b00, 8'h0F, 8'h05, 8'd3);
        idle(10);

        // Partial release followed by a release of already-clear bits.
        send(2'b00, 8'h0F, 8'hAA, 8'd0);
        idle(4);
        send(2'b01, 8'h3C, 8'h00, 8'd0);
        idle(4);
        send(2'b01, 8'hF0, 8'h00, 8'd0);
        idle(4);
        send(2'b10, 8'h00, 8'h00, 8'd0);
        idle(4);

        // Fill the FIFO while a long timed force is holding.
        send(2'b00, 8'hF0, 8'h5A, 8'd12);
        idle(3);
        send(2'b00, 8'h01, 8'h01, 8'd0);
        send(2'b00, 8'h02, 8'h00, 8'd2);
        send(2'b01, 8'h01, 8'h00, 8'd0);
        send(2'b00, 8'h80, 8'h80, 8'd0);
        send(2'b00, 8'h10, 8'h10, 8'd0);
        idle(40);

        // Abort during hold with two commands queued.
        send(2'b00, 8'hFF, 8'hC3, 8'd30);
        idle(3);
        send(2'b00, 8'h0F, 8'h0F, 8'd0);
        send(2'b01, 8'hFF, 8'h00, 8'd0);
        idle(3);
        step(1'b0, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1);
        idle(6);

        // Reserved opcode.
        send(2'b00, 8'h33, 8'h21, 8'd0);
        send(2'b11, 8'h33, 8'h00, 8'd0);
        idle(5);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            int         sel;
            logic [1:0] op;
            sel = int'($urandom_range(0, 9));
            op  = (sel < 5) ? 2'b00 : (sel < 8) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            step(($urandom_range(0, 1) == 1), op, 8'($urandom), 8'($urandom),
                 8'($urandom_range(0, 6)), ($urandom_range(0, 39) == 0));
        end
        idle(20);

        // Reset in the middle of a hold: no release strobe may appear.
        send(2'b00, 8'h3C, 8'h24, 8'd10);
        idle(4);
        chk("hold_active", force_en, 8'h3C);
        do_reset();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
